// File: rtl/fifo_hs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_hs : synchronous valid/ready FIFO with level flags and high watermark
// Revision: 1.0
// ----------------------------------------------------------------------------
module fifo_hs #(
  parameter int D_W      = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1,
  localparam int OW      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [D_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [D_W-1:0] out_data,
  output logic [OW-1:0]         occup,
  output logic [OW-1:0]         max_occup,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] C_LAST_PTR = PW'(DEPTH - 1);
  localparam logic [OW-1:0] C_DEPTH    = OW'(DEPTH);
  localparam logic [OW-1:0] C_AF       = OW'(AF_LEVEL);
  localparam logic [OW-1:0] C_AE       = OW'(AE_LEVEL);

  logic signed [D_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_rdaddr;
  logic [PW-1:0]         r_wraddr;
  logic [OW-1:0]         r_occup;
  logic [OW-1:0]         r_max;
  logic                  w_push;
  logic                  w_pop;
  logic [OW-1:0]         w_occup_nxt;

  assign in_ready     = (r_occup != C_DEPTH);
  assign out_valid    = (r_occup != '0);
  assign w_push       = in_valid & in_ready;
  assign w_pop        = out_valid & out_ready;
  assign out_data     = r_mem[r_rdaddr];
  assign occup        = r_occup;
  assign max_occup    = r_max;
  assign almost_full  = (r_occup >= C_AF);
  assign almost_empty = (r_occup <= C_AE);

  always_comb begin
    w_occup_nxt = r_occup;
    if (w_push && !w_pop) begin
      w_occup_nxt = r_occup + OW'(1);
    end else if (!w_push && w_pop) begin
      w_occup_nxt = r_occup - OW'(1);
    end
  end

  // Storage is deliberately left out of reset; a discarded push during flush never lands.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wraddr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdaddr <= '0;
      r_wraddr <= '0;
      r_occup  <= '0;
      r_max    <= '0;
    end else if (flush) begin
      r_rdaddr <= '0;
      r_wraddr <= '0;
      r_occup  <= '0;
      r_max    <= '0;
    end else begin
      if (w_push) begin
        r_wraddr <= (r_wraddr == C_LAST_PTR) ? '0 : r_wraddr + PW'(1);
      end
      if (w_pop) begin
        r_rdaddr <= (r_rdaddr == C_LAST_PTR) ? '0 : r_rdaddr + PW'(1);
      end
      r_occup <= w_occup_nxt;
      // Watermark tracks the registered level, so it trails occup by one cycle.
      if (r_occup > r_max) begin
        r_max <= r_occup;
      end
    end
  end

endmodule
`default_nettype wire
